// File: rtl/m68k_script_master.sv
// m68k_script_master: scripted 68010-style bus master with fault reporting.
// Define M68K_SCRIPT_CHECK_EN to compare read data against the expect field.
module m68k_script_master #(
  parameter int ADDR_W       = 24,
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 32,
  parameter int TIMEOUT      = 64,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic                           clk40,
  input  logic                           reset,
  input  logic                           ld_en,
  input  logic [$clog2(DEPTH)-1:0]       ld_idx,
  input  logic [ADDR_W+6+2*DATA_W-1:0]   ld_entry,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           pass,
  output logic [$clog2(DEPTH+1)-1:0]     err_count,
  output logic [$clog2(DEPTH)-1:0]       first_fail,
  output logic [1:0]                     fault_code,
  output logic [ADDR_W-1:0]              a,
  output logic [2:0]                     fc,
  output logic                           rw,
  output logic                           as_n,
  output logic                           uds_n,
  output logic                           lds_n,
  output logic [DATA_W-1:0]              dout,
  input  logic [DATA_W-1:0]              din,
  input  logic                           dtack_n,
  input  logic                           berr_n
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int EW = ADDR_W+6+2*DATA_W;
  localparam int HW = DATA_W/2;
  localparam int A0 = 2*DATA_W+6;

  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH-1);
  localparam logic [CW-1:0] ERR_MAX  = CW'(DEPTH);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_STROBE,
    S_WAIT,
    S_END,
    S_DONE
  } state_t;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     nidx;
  logic [TW-1:0]     tcnt;
  logic [1:0]        flt;
  logic [1:0]        f_now;
  logic [DATA_W-1:0] rdata;
  logic              mism;
  logic              unused_ok;

  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     cur;
  logic [EW-1:0]     nxt;

  logic              c_a0;
  logic              c_rw;
  logic              c_size;
  logic              c_last;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] c_exp;

  // Script storage keeps its contents across reset.
  always_ff @(posedge clk40) begin
    if (ld_en && !busy)
      mem[ld_idx] <= ld_entry;
  end

  assign cur     = mem[idx];
  assign nidx    = (state == S_IDLE) ? '0 : idx + 1'b1;
  assign nxt     = mem[nidx];

  assign c_a0    = cur[A0];
  assign c_rw    = cur[2*DATA_W+2];
  assign c_size  = cur[2*DATA_W+1];
  assign c_last  = cur[2*DATA_W];
  assign c_wdata = cur[2*DATA_W-1 -: DATA_W];
  assign c_exp   = cur[DATA_W-1:0];

`ifdef M68K_SCRIPT_CHECK_EN
  // Byte reads compare only the lane that was strobed.
  always_comb begin
    mism = 1'b0;
    if (c_rw) begin
      if (c_size)
        mism = rdata != c_exp;
      else if (c_a0)
        mism = rdata[HW-1:0] != c_exp[HW-1:0];
      else
        mism = rdata[DATA_W-1:HW] != c_exp[DATA_W-1:HW];
    end
  end
  assign unused_ok = ^{cur[EW-1:A0+1], cur[A0-1:A0-3],
                       nxt[2*DATA_W+1:0]};
`else
  assign mism = 1'b0;
  assign unused_ok = ^{cur[EW-1:A0+1], cur[A0-1:A0-3],
                       nxt[2*DATA_W+1:0], c_exp, rdata};
`endif

  assign f_now = (flt != 2'd0) ? flt : {1'b0, mism};

  always_ff @(posedge clk40 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      tcnt       <= '0;
      flt        <= 2'd0;
      rdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b1;
      err_count  <= '0;
      first_fail <= '0;
      fault_code <= 2'd0;
      a          <= '0;
      fc         <= 3'd0;
      rw         <= 1'b1;
      as_n       <= 1'b1;
      uds_n      <= 1'b1;
      lds_n      <= 1'b1;
      dout       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= S_ADDR;
            idx        <= '0;
            flt        <= 2'd0;
            busy       <= 1'b1;
            err_count  <= '0;
            first_fail <= '0;
            fault_code <= 2'd0;
            a          <= nxt[EW-1 -: ADDR_W];
            fc         <= nxt[A0-1 -: 3];
            rw         <= nxt[2*DATA_W+2];
          end
        end
        S_ADDR: begin
          if (c_size && c_a0) begin
            flt   <= 2'd2;
            state <= S_END;
          end else begin
            state <= S_STROBE;
            as_n  <= 1'b0;
            uds_n <= !(c_size || !c_a0);
            lds_n <= !(c_size || c_a0);
            if (!c_rw)
              dout <= c_size ? c_wdata : {2{c_wdata[HW-1:0]}};
          end
        end
        S_STROBE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (!berr_n) begin
            flt   <= 2'd2;
            as_n  <= 1'b1;
            uds_n <= 1'b1;
            lds_n <= 1'b1;
            state <= S_END;
          end else if (!dtack_n) begin
            rdata <= din;
            as_n  <= 1'b1;
            uds_n <= 1'b1;
            lds_n <= 1'b1;
            state <= S_END;
          end else if (tcnt == TO_MAX) begin
            flt   <= 2'd3;
            as_n  <= 1'b1;
            uds_n <= 1'b1;
            lds_n <= 1'b1;
            state <= S_END;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_END: begin
          if (f_now != 2'd0) begin
            if (err_count != ERR_MAX)
              err_count <= err_count + 1'b1;
            if (err_count == '0) begin
              first_fail <= idx;
              fault_code <= f_now;
            end
          end
          if (c_last || idx == LAST_IDX ||
              (STOP_ON_FAIL != 0 && f_now != 2'd0)) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_count == '0) && (f_now == 2'd0);
          end else begin
            state <= S_ADDR;
            idx   <= nidx;
            flt   <= 2'd0;
            a     <= nxt[EW-1 -: ADDR_W];
            fc    <= nxt[A0-1 -: 3];
            rw    <= nxt[2*DATA_W+2];
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_script_master.sv
// tb_m68k_script_master: directed scripts with result and bus scoreboards.
// Expected results are queued at issue time and popped by the monitors.
`timescale 1ns/1ps
module tb_m68k_script_master;

  localparam int AW = 24;
  localparam int DW = 16;
  localparam int DEPTH = 32;
  localparam int TO = 64;
  localparam int EW = AW+6+2*DW;

  logic          clk40 = 1'b0;
  logic          reset = 1'b1;
  logic          ld_en = 1'b0;
  logic [4:0]    ld_idx = '0;
  logic [EW-1:0] ld_entry = '0;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [5:0]    err_count;
  logic [4:0]    first_fail;
  logic [1:0]    fault_code;
  logic [AW-1:0] a;
  logic [2:0]    fc;
  logic          rw, as_n, uds_n, lds_n;
  logic [DW-1:0] dout;
  logic [DW-1:0] din;
  logic          dtack_n, berr_n;

  m68k_script_master #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH),
    .TIMEOUT(TO), .STOP_ON_FAIL(0)
  ) dut (
    .clk40(clk40), .reset(reset),
    .ld_en(ld_en), .ld_idx(ld_idx), .ld_entry(ld_entry),
    .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail),
    .fault_code(fault_code),
    .a(a), .fc(fc), .rw(rw),
    .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n),
    .dout(dout), .din(din),
    .dtack_n(dtack_n), .berr_n(berr_n)
  );

  always #5 clk40 = ~clk40;

  typedef struct {
    logic pass; int err; int ff; int code; int lat;
  } res_t;
  typedef struct {
    logic [AW-1:0] a; logic [2:0] fc; logic rw;
    logic uds; logic lds; logic [DW-1:0] dout; int dur;
  } bus_t;
  typedef struct {
    int kind; int waits; logic [DW-1:0] data;
  } rsp_t;

  res_t res_q[$];
  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int total = 0;
  int bad = 0;
  int ndone = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk40) cyc++;

  function automatic void chk(string nm, longint act, longint want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endfunction

  function automatic logic [EW-1:0] mk(
    logic [AW-1:0] ad, logic [2:0] f, logic r, logic s,
    logic l, logic [DW-1:0] wd, logic [DW-1:0] ex);
    return {ad, f, r, s, l, wd, ex};
  endfunction

  task automatic push_res(logic p, int e, int ff, int c, int lat);
    res_t r;
    r.pass = p; r.err = e; r.ff = ff; r.code = c; r.lat = lat;
    res_q.push_back(r);
  endtask

  task automatic push_bus(logic [AW-1:0] ad, logic [2:0] f,
                          logic r, logic u, logic l,
                          logic [DW-1:0] d, int dur);
    bus_t b;
    b.a = ad; b.fc = f; b.rw = r; b.uds = u; b.lds = l;
    b.dout = d; b.dur = dur;
    bus_q.push_back(b);
  endtask

  task automatic push_rsp(int k, int w, logic [DW-1:0] d);
    rsp_t r;
    r.kind = k; r.waits = w; r.data = d;
    rsp_q.push_back(r);
  endtask

  // Result monitor: pops on each done pulse.
  res_t me;
  always @(negedge clk40) begin
    if (done) begin
      if (res_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done: unexpected pulse");
      end else begin
        me = res_q.pop_front();
        chk("pass", pass, me.pass);
        chk("err_count", err_count, me.err);
        chk("first_fail", first_fail, me.ff);
        chk("fault_code", fault_code, me.code);
        chk("latency", cyc - start_cyc, me.lat);
        chk("busy_at_done", busy, 0);
      end
      ndone++;
    end
  end

  // Bus monitor: pops on each as_n fall, checks strobe length on rise.
  bus_t cb;
  logic cb_ok = 1'b0;
  logic prev_as = 1'b1;
  int   dur_cnt = 0;
  always @(negedge clk40) begin
    if (!as_n && prev_as) begin
      dur_cnt = 1;
      if (bus_q.size() == 0) begin
        total++;
        bad++;
        cb_ok = 1'b0;
        $display("FAIL bus: unexpected as_n at a=%0h", a);
      end else begin
        cb = bus_q.pop_front();
        cb_ok = 1'b1;
        chk("bus_a", a, cb.a);
        chk("bus_fc", fc, cb.fc);
        chk("bus_rw", rw, cb.rw);
        chk("bus_uds_n", uds_n, cb.uds);
        chk("bus_lds_n", lds_n, cb.lds);
        if (!cb.rw) chk("bus_dout", dout, cb.dout);
      end
    end else if (!as_n) begin
      dur_cnt++;
    end else if (!prev_as && cb_ok && cb.dur != 0) begin
      chk("as_len", dur_cnt, cb.dur);
    end
    prev_as = as_n;
  end

  // Slave responder: kind 0 dtack, 1 berr, 2 silent.
  rsp_t rr;
  initial begin
    dtack_n = 1'b1;
    berr_n = 1'b1;
    din = '0;
    forever begin
      @(negedge clk40);
      if (!as_n) begin
        if (rsp_q.size() != 0) rr = rsp_q.pop_front();
        else begin rr.kind = 2; rr.waits = 0; rr.data = '0; end
        for (int k = 0; k <= rr.waits && !as_n; k++)
          @(negedge clk40);
        if (!as_n) begin
          din = rr.data;
          if (rr.kind == 1) berr_n = 1'b0;
          else if (rr.kind == 0) dtack_n = 1'b0;
        end
        while (!as_n) @(negedge clk40);
        dtack_n = 1'b1;
        berr_n = 1'b1;
      end
    end
  end

  task automatic load(int i, logic [EW-1:0] e);
    @(negedge clk40);
    ld_en = 1'b1;
    ld_idx = 5'(i);
    ld_entry = e;
    @(negedge clk40);
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk40);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk40);
    start = 1'b0;
  endtask

  task automatic wait_done(int n0);
    for (int k = 0; k < 300 && ndone == n0; k++)
      @(negedge clk40);
    total++;
    if (ndone == n0) begin
      bad++;
      $display("FAIL run_timeout: got no done want done");
    end
    @(negedge clk40);
  endtask

  task automatic run();
    int n0;
    n0 = ndone;
    pulse_start();
    wait_done(n0);
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge clk40);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 1);
    chk("rst_err", err_count, 0);
    chk("rst_ff", first_fail, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_a", a, 0);
    chk("rst_fc", fc, 0);
    chk("rst_rw", rw, 1);
    chk("rst_strobes", {as_n, uds_n, lds_n}, 3'b111);
    chk("rst_dout", dout, 0);
    @(negedge clk40);
    reset = 1'b0;

    // word read, zero wait states
    load(0, mk(24'h000000, 3'd5, 1, 1, 1, 16'h0, 16'h00A5));
    push_rsp(0, 0, 16'h00A5);
    push_bus(24'h000000, 3'd5, 1, 0, 0, 16'h0, 2);
    push_res(1, 0, 0, 0, 5);
    run();

    // byte write to odd address, one wait state
    load(0, mk(24'h001801, 3'd5, 0, 0, 1, 16'h0034, 16'h0));
    push_rsp(0, 1, 16'h0);
    push_bus(24'h001801, 3'd5, 0, 1, 0, 16'h3434, 3);
    push_res(1, 0, 0, 0, 6);
    run();

    // three entries, BERR on entry 1
    load(0, mk(24'h000000, 3'd5, 1, 1, 0, 16'h0, 16'h00A5));
    load(1, mk(24'h001000, 3'd5, 1, 1, 0, 16'h0, 16'h0));
    load(2, mk(24'h001801, 3'd5, 0, 0, 1, 16'h0034, 16'h0));
    push_rsp(0, 0, 16'h00A5);
    push_rsp(1, 0, 16'h0);
    push_rsp(0, 0, 16'h0);
    push_bus(24'h000000, 3'd5, 1, 0, 0, 16'h0, 2);
    push_bus(24'h001000, 3'd5, 1, 0, 0, 16'h0, 2);
    push_bus(24'h001801, 3'd5, 0, 1, 0, 16'h3434, 2);
    push_res(0, 1, 1, 2, 13);
    run();

    // timeout
    load(0, mk(24'h000100, 3'd6, 1, 1, 1, 16'h0, 16'h0));
    push_rsp(2, 0, 16'h0);
    push_bus(24'h000100, 3'd6, 1, 0, 0, 16'h0, TO + 1);
    push_res(0, 1, 0, 3, TO + 4);
    run();

    // misaligned word: no bus cycle
    load(0, mk(24'h000005, 3'd5, 1, 1, 1, 16'h0, 16'h0));
    push_res(0, 1, 0, 2, 3);
    run();

    // mismatching word read
    load(0, mk(24'h000200, 3'd5, 1, 1, 1, 16'h0, 16'h00A5));
    push_rsp(0, 0, 16'h1234);
    push_bus(24'h000200, 3'd5, 1, 0, 0, 16'h0, 2);
`ifdef M68K_SCRIPT_CHECK_EN
    push_res(0, 1, 0, 1, 5);
`else
    push_res(1, 0, 0, 0, 5);
`endif
    run();

    // byte lanes, misaligned write, lane mismatch, word write
    load(0, mk(24'h000003, 3'd1, 1, 0, 0, 16'h0, 16'h77A5));
    load(1, mk(24'h000002, 3'd2, 1, 0, 0, 16'h0, 16'hA500));
    load(2, mk(24'h000007, 3'd3, 0, 1, 0, 16'h1111, 16'h0));
    load(3, mk(24'h000004, 3'd1, 1, 0, 0, 16'h0, 16'h1100));
    load(4, mk(24'h000008, 3'd2, 0, 1, 1, 16'hBEEF, 16'h0));
    push_rsp(0, 0, 16'h12A5);
    push_rsp(0, 0, 16'hA5FF);
    push_rsp(0, 0, 16'h2200);
    push_rsp(0, 2, 16'h0);
    push_bus(24'h000003, 3'd1, 1, 1, 0, 16'h0, 2);
    push_bus(24'h000002, 3'd2, 1, 0, 1, 16'h0, 2);
    push_bus(24'h000004, 3'd1, 1, 0, 1, 16'h0, 2);
    push_bus(24'h000008, 3'd2, 0, 0, 0, 16'hBEEF, 4);
`ifdef M68K_SCRIPT_CHECK_EN
    push_res(0, 2, 2, 2, 21);
`else
    push_res(0, 1, 2, 2, 21);
`endif
    run();

    // reset in WAIT, then rerun the preserved script
    load(0, mk(24'h000300, 3'd5, 1, 1, 1, 16'h0, 16'h5A5A));
    push_rsp(2, 0, 16'h0);
    push_bus(24'h000300, 3'd5, 1, 0, 0, 16'h0, 0);
    pulse_start();
    repeat (4) @(negedge clk40);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_strobes", {as_n, uds_n, lds_n}, 3'b111);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_err", err_count, 0);
    @(negedge clk40);
    reset = 1'b0;
    push_rsp(0, 0, 16'h5A5A);
    push_bus(24'h000300, 3'd5, 1, 0, 0, 16'h0, 2);
    push_res(1, 0, 0, 0, 5);
    run();

    // start while busy is ignored
    push_rsp(0, 5, 16'h5A5A);
    push_bus(24'h000300, 3'd5, 1, 0, 0, 16'h0, 7);
    push_res(1, 0, 0, 0, 10);
    n0 = ndone;
    pulse_start();
    repeat (2) @(negedge clk40);
    start = 1'b1;
    @(negedge clk40);
    start = 1'b0;
    wait_done(n0);
    repeat (10) @(negedge clk40);
    chk("idle_after_ignored_start", busy, 0);

    chk("res_q_left", res_q.size(), 0);
    chk("bus_q_left", bus_q.size(), 0);
    chk("rsp_q_left", rsp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/m68k_script_master.md
# m68k_script_master

Parametrised, synthesizable 68010-style bus master. It runs a loadable script of bus transactions (address, function code, direction, size, write data, expected read data) against the design's P1/P2 bus, and checks the results. It replaces hand-called per-transaction bus tasks in bench and bring-up flows, and can sit in place of the CPU to drive `top` directly. It adds byte/word sizing, read-data checking, bus-error and timeout handling, and fail reporting.

## Interface
- `ADDR_W`, 24: bus address width.
- `DATA_W`, 16: bus data width. Must be even; the two byte lanes are `DATA_W/2` each.
- `DEPTH`, 32: number of script entries.
- `TIMEOUT`, 64: clocks to wait for DTACK/BERR before a timeout fault.
- `STOP_ON_FAIL`, 0: 1 halts the script at the first fault.

Ports (name, direction, width, meaning):
- `clk40` in 1: sole clock; everything is on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `ld_en` in 1: script write strobe. Ignored while `busy`.
- `ld_idx` in clog2(DEPTH): entry written.
- `ld_entry` in ADDR_W+3+1+1+1+2·DATA_W: packed entry `{addr, fc, rw, size, last, wdata, expect}`. `rw` is 1 for read; `size` is 1 for word.
- `start` in 1: one-clock pulse that launches the script from entry 0.
- `busy` out 1: script is executing.
- `done` out 1: one-clock pulse when the script finishes.
- `pass` out 1: 1 if no fault occurred in the last run. Valid from `done` until the next `start`.
- `err_count` out clog2(DEPTH+1): number of faulted entries.
- `first_fail` out clog2(DEPTH): index of the first faulted entry.
- `fault_code` out 2: code of the first fault. 0 none, 1 read mismatch, 2 bus fault (BERR or misaligned word), 3 timeout.
- `a` out ADDR_W; `fc` out 3; `rw` out 1.
- `as_n`, `uds_n`, `lds_n` out 1 each: strobes, active-low.
- `dout` out DATA_W; `din` in DATA_W.
- `dtack_n`, `berr_n` in 1: active-low.

## Operation
- Script storage is a register array with no reset; contents survive `reset`. An entry is written on `clk40` when `ld_en=1` and `busy=0`.
- States:
  - IDLE: if `start`, go to ADDR with idx=0, clear the counters, `busy=1`.
  - ADDR: drive `a`, `fc`, `rw`. All strobes stay negated. A misaligned word (size=1, addr[0]=1) records fault 2 and goes to END with no bus cycle. Otherwise go to STROBE.
  - STROBE: `as_n=0`.
    - Word: `uds_n=lds_n=0`.
    - Byte: addr[0]=0 asserts `uds_n`; addr[0]=1 asserts `lds_n`.
    - Writes drive `dout` = wdata. Byte writes replicate the low byte onto both lanes.
    - Go to WAIT and clear the timeout counter.
  - WAIT: check in this order each clock.
    - `berr_n=0`: record fault 2, go to END.
    - Else `dtack_n=0`: latch `din`, go to END.
    - Else counter = TIMEOUT-1: record fault 3, go to END.
    - Else increment the counter.
  - END: negate all strobes. Run the read check (see Configuration). For a faulted entry, `err_count++`; if it is the first fault, capture `first_fail` and `fault_code`. Go to DONE if any of these holds: `last` is set, idx = DEPTH-1, or (STOP_ON_FAIL and a fault occurred). Otherwise idx++ and go to ADDR.
  - DONE: `done=1` for one clock, `busy=0`, go to IDLE.
- Byte-read checking compares only the selected lane against the corresponding byte of `expect`.
- `start` while busy is ignored.
- `err_count` saturates at DEPTH.

## Timing
- Reset values: state IDLE; `busy=0`, `done=0`, `pass=1`, `err_count=0`, `first_fail=0`, `fault_code=0`, `a=0`, `fc=0`, `rw=1`, `as_n=uds_n=lds_n=1`, `dout=0`.
- Reset mid-cycle negates all strobes immediately (asynchronously).
- Minimum transaction is 4 clocks (ADDR, STROBE, WAIT, END) when `dtack_n` is already low on the first WAIT clock. Each wait-state adds 1 clock.
- A timeout transaction takes TIMEOUT+3 clocks.
- A misaligned word takes 2 clocks (ADDR, END).
- `done` pulses 1 clock after the final END. `start` to first `as_n` low is 2 clocks.
- `dtack_n` and `berr_n` low on the same clock count as a BERR fault.

## Configuration
- `M68K_SCRIPT_CHECK_EN` defined: read entries compare the latched data against `expect`. A mismatch is fault 1.
- Not defined: reads are never compared, `expect` is ignored, and fault 1 never occurs. Only bus faults and timeouts are reported.

## Test plan
- Word read at 0x000000, fc=5, `dtack_n` low on the first WAIT, `din`=0x00A5, expect 0x00A5, last=1 -> 4-clock cycle, `uds_n=lds_n=0`, `done`, `pass=1`, `err_count=0`.
- Byte write at 0x001801, fc=5, wdata 0x0034 -> `lds_n=0`, `uds_n=1`, `dout=0x3434`, `rw=0`.
- Three entries where entry 1 (0x001000) gets BERR and STOP_ON_FAIL=0 -> all 3 run, `err_count=1`, `first_fail=1`, `fault_code=2`, `pass=0`.
- No DTACK with TIMEOUT=64 -> strobes negate after 64 WAIT clocks, `fault_code=3`.
- Word at 0x000005 -> no `as_n` assertion, fault 2. Mismatching read (din 0x1234, expect 0x00A5) -> fault 1 with the macro defined; `pass=1` without it.
- `reset` asserted during WAIT -> strobes high at once, `busy=0`; a subsequent `start` reruns the preserved script.
